key_press_conditioner: RTL and testbench

- Upstream input stage for the vending-machine controller.
- Takes the raw, bouncy, active-low KEY[0] push button and converts it into clean, synchronous, single-cycle events: press, release and long-press.
- Also provides a debounced level and a press counter.
- The controller consumes press_pulse as its "coin/select" event, so one physical press always yields exactly one pulse.

---
 rtl/key_press_conditioner.sv | 123 ++++++++++++
 tb/tb_key_press_conditioner.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/key_press_conditioner.sv
// Button conditioner: synchronises and debounces the active-low KEY_N and turns
// it into single-cycle press/release/long-press strobes plus a level and a count.
module key_press_conditioner #(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int LONG_CYCLES     = 50000000,
    parameter int CNT_W           = 26
) (
    input  logic       CLOCK_50,
    input  logic       RESET,
    input  logic       KEY_N,
    output logic       press_pulse,
    output logic       release_pulse,
    output logic       long_pulse,
    output logic       key_level,
    output logic [7:0] press_count
);

    typedef enum logic [1:0] {RELEASED, PRESS_CHK, PRESSED, REL_CHK} state_t;

    localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    logic             sync_a, s;
    state_t           state, state_nx;
    logic [CNT_W-1:0] dcnt, dcnt_nx;
    logic [CNT_W-1:0] lcnt, lcnt_nx;
    logic             long_done, long_done_nx;
    logic             press_nx, release_nx, long_nx, level_nx;
    logic [7:0]       count_nx;

    // Sync flops reset to the released level so a held key after reset is seen as a fresh press.
    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            sync_a        <= 1'b1;
            s             <= 1'b1;
            state         <= RELEASED;
            dcnt          <= '0;
            lcnt          <= '0;
            long_done     <= 1'b0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            long_pulse    <= 1'b0;
            key_level     <= 1'b0;
            press_count   <= '0;
        end else begin
            sync_a        <= KEY_N;
            s             <= sync_a;
            state         <= state_nx;
            dcnt          <= dcnt_nx;
            lcnt          <= lcnt_nx;
            long_done     <= long_done_nx;
            press_pulse   <= press_nx;
            release_pulse <= release_nx;
            long_pulse    <= long_nx;
            key_level     <= level_nx;
            press_count   <= count_nx;
        end
    end

    always_comb begin
        state_nx     = state;
        dcnt_nx      = dcnt;
        lcnt_nx      = lcnt;
        long_done_nx = long_done;
        press_nx     = 1'b0;
        release_nx   = 1'b0;
        long_nx      = 1'b0;
        level_nx     = key_level;
        count_nx     = press_count;
        case (state)
            RELEASED: begin
                if (!s) begin
                    state_nx = PRESS_CHK;
                    dcnt_nx  = '0;
                end
            end
            PRESS_CHK: begin
                if (s) begin
                    state_nx = RELEASED;
                    dcnt_nx  = '0;
                end else if (dcnt == DB_LAST) begin
                    state_nx     = PRESSED;
                    press_nx     = 1'b1;
                    level_nx     = 1'b1;
                    count_nx     = press_count + 8'd1;
                    lcnt_nx      = '0;
                    long_done_nx = 1'b0;
                end else begin
                    dcnt_nx = dcnt + CNT_ONE;
                end
            end
            PRESSED: begin
                // The long-press check runs even on the edge that leaves for REL_CHK.
                if (!long_done) begin
                    if (lcnt == LONG_LAST) begin
                        long_nx      = 1'b1;
                        long_done_nx = 1'b1;
                    end else begin
                        lcnt_nx = lcnt + CNT_ONE;
                    end
                end
                if (s) begin
                    state_nx = REL_CHK;
                    dcnt_nx  = '0;
                end
            end
            REL_CHK: begin
                if (!s) begin
                    state_nx = PRESSED;
                end else if (dcnt == DB_LAST) begin
                    state_nx   = RELEASED;
                    release_nx = 1'b1;
                    level_nx   = 1'b0;
                end else begin
                    dcnt_nx = dcnt + CNT_ONE;
                end
            end
            default: state_nx = RELEASED;
        endcase
    end

endmodule

// File: tb/tb_key_press_conditioner.sv
// Bench for key_press_conditioner: directed scenarios plus random key traffic,
// compared every cycle against a run-length based reference of the debounce rules.
module tb_key_press_conditioner;

    localparam int D = 4;
    localparam int L = 16;

    logic       CLOCK_50 = 1'b0;
    logic       RESET    = 1'b1;
    logic       KEY_N    = 1'b0;
    logic       press_pulse, release_pulse, long_pulse, key_level;
    logic [7:0] press_count;

    key_press_conditioner #(.DEBOUNCE_CYCLES(D), .LONG_CYCLES(L), .CNT_W(26)) dut (
        .CLOCK_50     (CLOCK_50),
        .RESET        (RESET),
        .KEY_N        (KEY_N),
        .press_pulse  (press_pulse),
        .release_pulse(release_pulse),
        .long_pulse   (long_pulse),
        .key_level    (key_level),
        .press_count  (press_count)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference: the level flips once D+1 consecutive synchronised samples disagree
    // with it; long press fires after L edges spent in the settled pressed condition.
    bit         hist[$];
    int         run, held;
    bit         m_level, m_long_done, last_s;
    bit         m_press, m_rel, m_long;
    logic [7:0] m_count;

    int nP = 0, nR = 0, nL = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        hist.delete();
        run = 0; held = 0;
        m_level = 0; m_long_done = 0; last_s = 1;
        m_press = 0; m_rel = 0; m_long = 0;
        m_count = 8'd0;
    endtask

    task automatic model_edge(input bit k);
        bit s;
        hist.push_back(k);
        s = (hist.size() >= 3) ? hist[hist.size()-3] : 1'b1;
        if (hist.size() > 3) void'(hist.pop_front());
        m_press = 0; m_rel = 0; m_long = 0;
        if (m_level && !m_long_done && !last_s) begin
            held++;
            if (held == L) begin m_long = 1; m_long_done = 1; end
        end
        if (m_level ? s : !s) run++;
        else run = 0;
        if (run == D + 1) begin
            run = 0;
            if (!m_level) begin
                m_level = 1; m_press = 1; m_count = m_count + 8'd1;
                held = 0; m_long_done = 0;
            end else begin
                m_level = 0; m_rel = 1;
            end
        end
        last_s = s;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_press"},   press_pulse,   0);
        check({tag, "_release"}, release_pulse, 0);
        check({tag, "_long"},    long_pulse,    0);
        check({tag, "_level"},   key_level,     0);
        check({tag, "_count"},   press_count,   0);
    endtask

    // Starts and ends just after a falling edge.
    task automatic cycle(input bit k);
        KEY_N = k;
        @(posedge CLOCK_50);
        model_edge(k);
        #1;
        check("press_pulse",   press_pulse,   m_press);
        check("release_pulse", release_pulse, m_rel);
        check("long_pulse",    long_pulse,    m_long);
        check("key_level",     key_level,     m_level);
        check("press_count",   press_count,   m_count);
        check("press_rel_excl", press_pulse & release_pulse, 0);
        nP += int'(press_pulse);
        nR += int'(release_pulse);
        nL += int'(long_pulse);
        @(negedge CLOCK_50);
    endtask

    task automatic hold(input bit k, input int n);
        repeat (n) cycle(k);
    endtask

    task automatic async_reset();
        #3 RESET = 1'b1;
        #1 model_reset();
        check_zero("async_reset");
        @(posedge CLOCK_50);
        @(negedge CLOCK_50);
        RESET = 1'b0;
    endtask

    initial begin
        int first, p0, r0, l0, pe, le;
        model_reset();
        #1 check_zero("reset_immediate");
        @(negedge CLOCK_50);
        RESET = 1'b0;

        // Key held through reset: press must take the full 7 edges.
        first = 0; p0 = nP;
        for (int i = 1; i <= 12; i++) begin
            cycle(1'b0);
            if (press_pulse && first == 0) first = i;
        end
        check("press_latency", first, 7);
        check("press_once", nP - p0, 1);
        first = 0;
        for (int i = 1; i <= 10; i++) begin
            cycle(1'b1);
            if (release_pulse && first == 0) first = i;
        end
        check("release_latency", first, 7);
        check("level_after_release", key_level, 0);

        // Bounce rejection then a clean press.
        p0 = nP;
        hold(0, 3); hold(1, 2); hold(0, 2); hold(1, 10);
        check("bounce_no_press", nP - p0, 0);
        check("bounce_count", press_count, 1);
        hold(0, 12); hold(1, 10);
        check("clean_press_once", nP - p0, 1);
        check("clean_count", press_count, 2);

        // Release glitch while pressed.
        p0 = nP; r0 = nR;
        hold(0, 9); hold(1, 2); hold(0, 4);
        check("glitch_level", key_level, 1);
        check("glitch_no_release", nR - r0, 0);
        check("glitch_one_press", nP - p0, 1);
        hold(1, 10);
        check("glitch_release_once", nR - r0, 1);

        // Long press.
        l0 = nL; r0 = nR; pe = 0; le = 0;
        for (int i = 1; i <= 40; i++) begin
            cycle(1'b0);
            if (press_pulse) pe = i;
            if (long_pulse && le == 0) le = i;
        end
        check("long_once", nL - l0, 1);
        check("long_delay", le - pe, L);
        hold(1, 10);
        check("long_release_once", nR - r0, 1);
        check("long_no_repeat", nL - l0, 1);

        // Random key traffic with an asynchronous reset in the middle.
        for (int r = 0; r < 80; r++) begin
            hold(1'($urandom_range(0, 1)), $urandom_range(1, 24));
            if (r == 40) async_reset();
        end
        hold(1, 10);

        // Counter wrap from a fresh reset.
        @(negedge CLOCK_50);
        async_reset();
        p0 = nP;
        for (int i = 1; i <= 256; i++) begin
            hold(0, 8);
            check("wrap_step", press_count, i % 256);
            hold(1, 8);
        end
        check("wrap_presses", nP - p0, 256);
        check("wrap_count", press_count, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
